// File: rtl/nbit_core_pkg.sv
// nbit_core_pkg: opcode, state and field-width definitions
// shared by the parametrised accumulator core.
package nbit_core_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h4;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h5;
  localparam logic [OP_W-1:0] OP_JZ   = 4'h6;
  localparam logic [OP_W-1:0] OP_JC   = 4'h7;
  localparam logic [OP_W-1:0] OP_MOVB = 4'h8;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h9;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/nbit_prog_mem.sv
// nbit_prog_mem: program store with one synchronous write
// port and a combinational read port (not reset).
module nbit_prog_mem
  import nbit_core_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nbit_prog_core.sv
// nbit_prog_core: accumulator processor with strobe-loaded
// program memory, Z/C flags, branches and a halt state.
module nbit_prog_core
  import nbit_core_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IMM_W    = 4,
  parameter int DEPTH    = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int INSTR_W = OP_W + IMM_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic [INSTR_W-1:0] instruc,
  input  logic               run,
  output logic [DATA_W-1:0]  port_1,
  output logic               busy,
  output logic               halted,
  output logic [AW:0]        prog_cnt,
  output logic               prog_full
);

  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0] wr_q, wr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] port_q, port_d;
  logic z_q, z_d;
  logic c_q, c_d;
  logic en_q;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic mem_we;
  logic en_rise;
  logic full;

  logic [OP_W-1:0] opcode;
  logic [IMM_W-1:0] imm;
  logic [DATA_W-1:0] imm_x;
  logic [AW-1:0] tgt;
  logic [DATA_W:0] add_i;
  logic [DATA_W:0] sub_i;
  logic [DATA_W:0] add_b;

  assign opcode = ir_q[INSTR_W-1 -: OP_W];
  assign imm = ir_q[IMM_W-1:0];
  assign imm_x = DATA_W'(imm);
  assign tgt = imm[AW-1:0];

  // MSB of the widened sums is carry; of the difference, borrow
  assign add_i = {1'b0, a_q} + {1'b0, imm_x};
  assign sub_i = {1'b0, a_q} - {1'b0, imm_x};
  assign add_b = {1'b0, a_q} + {1'b0, b_q};

  assign full = (wr_q == (AW+1)'(DEPTH));
  assign en_rise = enable & ~en_q;

  nbit_prog_mem #(
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(wr_q[AW-1:0]),
    .wdata_i(instruc),
    .raddr_i(pc_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    wr_d = wr_q;
    a_d = a_q;
    b_d = b_q;
    z_d = z_q;
    c_d = c_q;
    ir_d = ir_q;
    port_d = port_q;
    mem_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_rise && !full && !clear) begin
          mem_we = 1'b1;
          wr_d = wr_q + 1'b1;
        end
        if (run) begin
          state_d = ST_FETCH;
          pc_d = '0;
        end
      end
      ST_FETCH: begin
        ir_d = mem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d = pc_q + 1'b1;
        unique case (1'b1)
          (opcode == OP_LDI): begin
            a_d = imm_x;
            z_d = ~|imm_x;
          end
          (opcode == OP_ADDI): begin
            {c_d, a_d} = add_i;
            z_d = ~|add_i[DATA_W-1:0];
          end
          (opcode == OP_SUBI): begin
            {c_d, a_d} = sub_i;
            z_d = ~|sub_i[DATA_W-1:0];
          end
          (opcode == OP_OUT): port_d = a_q;
          (opcode == OP_JMP): pc_d = tgt;
          (opcode == OP_JZ): if (z_q) pc_d = tgt;
          (opcode == OP_JC): if (c_q) pc_d = tgt;
          (opcode == OP_MOVB): b_d = a_q;
          (opcode == OP_ADD): begin
            {c_d, a_d} = add_b;
            z_d = ~|add_b[DATA_W-1:0];
          end
          (opcode == OP_HLT): state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_HALT: begin
        if (run) begin
          state_d = ST_FETCH;
          pc_d = '0;
          a_d = '0;
          b_d = '0;
          z_d = 1'b0;
          c_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      pc_q <= '0;
      wr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      ir_q <= '0;
      port_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      wr_q <= wr_d;
      a_q <= a_d;
      b_q <= b_d;
      z_q <= z_d;
      c_q <= c_d;
      ir_q <= ir_d;
      port_q <= port_d;
      en_q <= enable;
    end
  end

  assign port_1 = port_q;
  assign busy = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALT);
  assign prog_cnt = wr_q;
  assign prog_full = full;

endmodule

// File: tb/tb_nbit_prog_core.sv
// tb_nbit_prog_core: directed program table, corner sequences
// and random programs against an instruction-level model.
module tb_nbit_prog_core;

  logic clk;
  logic clear;
  logic enable;
  logic [7:0] instruc;
  logic run;
  logic [7:0] port_1;
  logic busy;
  logic halted;
  logic [4:0] prog_cnt;
  logic prog_full;

  nbit_prog_core #(
    .DATA_W(8),
    .IMM_W (4),
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .enable   (enable),
    .instruc  (instruc),
    .run      (run),
    .port_1   (port_1),
    .busy     (busy),
    .halted   (halted),
    .prog_cnt (prog_cnt),
    .prog_full(prog_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:7][7:0] prog;
    int len;
    logic [7:0] port;
    int n;
  } vec_t;

  vec_t tv [6];

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] mmem [16];
  int m_cnt = 0;
  int m_port = 0;
  int m_n;
  bit m_halt;
  int exp_p [256];

  logic [7:0] obs_p [256];
  bit obs_h [256];
  bit obs_b [256];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction-level model: each instruction takes a fetch and an
  // execute edge; the port shows the OUT value after the execute edge.
  task automatic model_exec(input int maxi);
    int a, b, pc, op, imm, t;
    bit z, c;
    a = 0; b = 0; pc = 0; z = 0; c = 0;
    m_n = 0;
    m_halt = 0;
    while (!m_halt && m_n < maxi) begin
      op = int'(mmem[pc]) / 16;
      imm = int'(mmem[pc]) % 16;
      exp_p[2*m_n] = m_port;
      pc = (pc + 1) % 16;
      case (op)
        1: begin a = imm; z = (a == 0); end
        2: begin t = a + imm; c = (t > 255); a = t % 256; z = (a == 0); end
        3: begin c = (a < imm); a = (a - imm + 256) % 256; z = (a == 0); end
        4: m_port = a;
        5: pc = imm;
        6: if (z) pc = imm;
        7: if (c) pc = imm;
        8: b = a;
        9: begin t = a + b; c = (t > 255); a = t % 256; z = (a == 0); end
        15: m_halt = 1;
        default: ;
      endcase
      exp_p[2*m_n+1] = m_port;
      m_n++;
    end
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    m_cnt = 0;
    m_port = 0;
  endtask

  task automatic load(input logic [7:0] w, input int hold);
    enable = 1;
    instruc = w;
    repeat (hold) @(posedge clk);
    #1;
    enable = 0;
    @(posedge clk); #1;
    if (m_cnt < 16) begin
      mmem[m_cnt] = w;
      m_cnt++;
    end
  endtask

  task automatic pulse_ignored();
    enable = 1;
    instruc = 8'hF0;
    @(posedge clk); #1;
    enable = 0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_run();
    run = 1;
    @(posedge clk); #1;
    run = 0;
  endtask

  task automatic watch(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      obs_p[i] = port_1;
      obs_h[i] = halted;
      obs_b[i] = busy;
    end
  endtask

  task automatic cmp_trace(input string nm, input int ncyc);
    int bad;
    bit eh;
    bad = -1;
    for (int i = 0; i < ncyc; i++) begin
      eh = m_halt && (i == ncyc - 1);
      if (bad < 0 && (obs_p[i] !== 8'(exp_p[i]) ||
          obs_h[i] !== eh || obs_b[i] !== !eh)) bad = i;
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      eh = m_halt && (bad == ncyc - 1);
      $display("FAIL %s: cycle %0d port %0h halted %0b busy %0b, expected port %0h halted %0b busy %0b",
               nm, bad + 1, obs_p[bad], obs_h[bad], obs_b[bad],
               8'(exp_p[bad]), eh, !eh);
    end
  endtask

  initial begin
    tv[0] = '{prog: {8'h15, 8'h40, 8'hF0, 40'h0}, len: 3, port: 8'h05, n: 3};
    tv[1] = '{prog: {8'h10, 8'h31, 8'h74, 8'hF0, 8'h40, 8'hF0, 16'h0},
              len: 6, port: 8'hFF, n: 5};
    tv[2] = '{prog: {8'h13, 8'h31, 8'h40, 8'h65, 8'h51, 8'hF0, 16'h0},
              len: 6, port: 8'h00, n: 13};
    tv[3] = '{prog: {8'h10, 8'h31, 8'h80, 8'h90, 8'h76, 8'hF0, 8'h40, 8'hF0},
              len: 8, port: 8'hFE, n: 7};
    tv[4] = '{prog: {8'h1F, 8'hA0, 8'h2F, 8'hE5, 8'h40, 8'hF0, 16'h0},
              len: 6, port: 8'h1E, n: 6};
    tv[5] = '{prog: {8'h10, 8'h31, 8'h21, 8'h65, 8'hF0, 8'h17, 8'h40, 8'hF0},
              len: 8, port: 8'h07, n: 7};
    for (int i = 0; i < 16; i++) mmem[i] = 8'h00;

    clk = 0;
    clear = 1;
    enable = 0;
    instruc = 8'h00;
    run = 0;
    repeat (2) @(posedge clk);
    #1;
    clear = 0;
    m_cnt = 0;
    m_port = 0;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_port", port_1, 0);
    chk("rst_cnt", prog_cnt, 0);
    chk("rst_full", prog_full, 0);

    // Full memory, ignored 17th word, wrap-around of NOPs
    do_clear();
    for (int j = 0; j < 17; j++) load((j == 16) ? 8'hF0 : 8'h00, 1);
    chk("full_cnt", prog_cnt, 16);
    chk("full_flag", prog_full, 1);
    model_exec(20);
    pulse_run();
    watch(40);
    cmp_trace("wrap_trace", 40);
    pulse_ignored();
    chk("full_busy_cnt", prog_cnt, 16);

    // Directed program table
    for (int k = 0; k < 6; k++) begin
      do_clear();
      for (int j = 0; j < tv[k].len; j++)
        load(tv[k].prog[j], (k == 0) ? 3 : 1);
      chk($sformatf("tv%0d_cnt", k), prog_cnt, tv[k].len);
      chk($sformatf("tv%0d_idle", k), busy, 0);
      model_exec(64);
      pulse_run();
      watch(2 * tv[k].n);
      cmp_trace($sformatf("tv%0d_trace", k), 2 * tv[k].n);
      chk($sformatf("tv%0d_nothalt", k), obs_h[2*tv[k].n-2], 0);
      chk($sformatf("tv%0d_halt", k), obs_h[2*tv[k].n-1], 1);
      chk($sformatf("tv%0d_port", k), obs_p[2*tv[k].n-1], tv[k].port);
      if (k == 0) begin
        chk("tv0_port_c3", obs_p[2], 8'h00);
        chk("tv0_port_c4", obs_p[3], 8'h05);
        pulse_ignored();
        chk("halt_wr_cnt", prog_cnt, 3);
        chk("halt_hold_port", port_1, 8'h05);
      end
      if (k == 2) begin
        model_exec(64);
        pulse_run();
        watch(26);
        cmp_trace("restart_trace", 26);
        chk("restart_out1", obs_p[5], 8'h02);
        chk("restart_out2", obs_p[13], 8'h01);
        chk("restart_out3", obs_p[21], 8'h00);
        chk("restart_halt", obs_h[25], 1);
      end
    end

    // Write strobe and run in the same IDLE cycle
    do_clear();
    load(8'h17, 1);
    load(8'h40, 1);
    enable = 1;
    instruc = 8'hF0;
    run = 1;
    @(posedge clk); #1;
    enable = 0;
    run = 0;
    mmem[2] = 8'hF0;
    m_cnt = 3;
    model_exec(16);
    watch(6);
    cmp_trace("wrrun_trace", 6);
    chk("wrrun_cnt", prog_cnt, 3);
    chk("wrrun_port", obs_p[3], 8'h07);

    // Writes while busy, then clear mid-run
    do_clear();
    for (int j = 0; j < 6; j++) load(tv[2].prog[j], 1);
    pulse_run();
    watch(8);
    pulse_ignored();
    pulse_ignored();
    chk("busy_wr_cnt", prog_cnt, 6);
    chk("busy_mid", busy, 1);
    chk("port_mid", port_1, 8'h02);
    do_clear();
    chk("clr_busy", busy, 0);
    chk("clr_halted", halted, 0);
    chk("clr_port", port_1, 0);
    chk("clr_cnt", prog_cnt, 0);
    for (int j = 0; j < 3; j++) load(tv[0].prog[j], 1);
    model_exec(16);
    pulse_run();
    watch(6);
    cmp_trace("reload_trace", 6);
    chk("reload_port", obs_p[3], 8'h05);

    // Random programs over partly stale memory
    for (int r = 0; r < 25; r++) begin
      int len;
      do_clear();
      len = $urandom_range(1, 16);
      for (int j = 0; j < len; j++) load(8'($urandom), 1);
      chk($sformatf("rnd%0d_cnt", r), prog_cnt, len);
      model_exec(50);
      pulse_run();
      watch(2 * m_n);
      cmp_trace($sformatf("rnd%0d_trace", r), 2 * m_n);
      chk($sformatf("rnd%0d_halt", r), halted, m_halt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
